fast_arc_detector: RTL
======================

FAST_ARC_DETECTOR -- requirements
Module: fast_arc_detector

Interface
REQ-001 Parameter PIX_W, default 8, sets the pixel width in bits.
REQ-002 Parameter ARC_LEN, default 4, sets the required contiguous ring arc length; legal range is 2..8.
REQ-003 Parameter CNT_W, default 16, sets the keypoint counter width.
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- thresh, in, PIX_W, intensity threshold, sampled on input accept.
- frame_start, in, 1, single-cycle pulse that clears kp_count.
- in_valid, in, 1, window valid.
- in_ready, out, 1, window accepted when in_valid && in_ready.
- in_win, in, 9*PIX_W, 3x3 window; pixel (r,c) sits at bits [PIX_W*(3r+c) +: PIX_W], where r=0 is the top row and c=0 is the lowest field in a row.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed when out_valid && out_ready.
- out_kp, out, 1, keypoint detected.
- out_bright, out, 1, 1 = bright arc, 0 = dark arc; 0 when out_kp=0.
- out_score, out, PIX_W+3, corner score.
- kp_count, out, CNT_W, keypoints delivered since the last frame_start or reset.

Function
REQ-005 Ring order SHALL be P0=(0,0), P1=(0,1), P2=(0,2), P3=(1,2), P4=(2,2), P5=(2,1), P6=(2,0), P7=(1,0); the centre C is (1,1).
REQ-006 Brighter[i] SHALL be Pi > C+thresh, with the sum evaluated in PIX_W+1 bits so it never wraps.
REQ-007 Darker[i] SHALL be Pi+thresh < C, evaluated in PIX_W+1 bits; when C < thresh, no pixel is darker.
REQ-008 A bright arc SHALL exist when ARC_LEN circularly contiguous ring pixels are brighter; wrap P7->P0 is included.
REQ-009 A dark arc SHALL be detected by the same rule applied to the darker flags.
REQ-010 out_kp SHALL be the OR of the bright-arc and dark-arc results; out_bright SHALL be the bright-arc result.
REQ-011 out_score SHALL be the sum over P0..P7 of |Pi-C|, unsigned, with no saturation (maximum 8*(2^PIX_W-1)).
REQ-012 The datapath SHALL be two register stages:
- Stage 1 registers the brighter/darker flags and the absolute differences.
- Stage 2 registers the arc result and the score sum.
REQ-013 With out_ready held high, a window accepted in cycle N SHALL appear with out_valid=1 in cycle N+2, and one window SHALL be accepted per cycle.
REQ-014 Stall rule: the pipeline advances when advance = out_ready || !out_valid.
- in_ready SHALL equal advance.
- Stage-valid bits SHALL propagate on advance; a bubble is inserted when in_valid=0.
REQ-015 While out_valid=1 and out_ready=0, out_kp, out_bright and out_score SHALL hold stable, and no input SHALL be accepted.
REQ-016 kp_count SHALL increment on each output handshake with out_kp=1 and SHALL saturate at 2^CNT_W-1.
REQ-017 frame_start SHALL set kp_count to 0 on the next edge and take priority over a same-cycle increment; frame_start SHALL NOT flush the pipeline.
REQ-018 thresh changes SHALL affect only windows accepted after the change.

Reset
REQ-019 When rst_n=0, all of the following SHALL clear to 0 asynchronously: stage valids, out_valid, out_kp, out_bright, out_score and kp_count.
REQ-020 While in reset, in_ready SHALL read 1, since out_valid=0.
REQ-021 Reset mid-stream SHALL discard all in-flight windows; the first window accepted after reset release SHALL appear two cycles later.

Verification
REQ-022 Bright arc: PIX_W=8, ARC_LEN=4, thresh=7, C=100, P0..P3=120, P4..P7=100 -> out_kp=1, out_bright=1, out_score=80 at cycle N+2.
REQ-023 Wrapped dark arc: C=100, P6, P7, P0, P1=50, others=100 -> out_kp=1, out_bright=0, out_score=200.
REQ-024 Overflow and underflow cases -> out_kp=0 for each:
- C=250, thresh=10, all ring pixels 255.
- C=3, thresh=7, all ring pixels 0.
REQ-025 Backpressure: stream 4 keypoint windows, drop out_ready for 3 cycles after the first output.
- The output holds stable and in_ready=0 during the stall.
- All 4 results arrive in order; kp_count=4.
REQ-026 Counter with CNT_W=2: 5 keypoint handshakes -> kp_count=3 (saturated).
- frame_start coincident with a keypoint handshake -> kp_count=0.
REQ-027 Reset mid-stream: assert rst_n=0 while 2 windows are in flight.
- out_valid=0 and kp_count=0 immediately.
- No stale result appears after release.

Source files
------------

// File: rtl/fast_arc_detector.sv
// FAST-style 3x3 ring corner detector.
// Two register stages with a valid/ready stall; counts delivered keypoints.
module fast_arc_detector #(
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   thresh,
  input  logic               frame_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*PIX_W-1:0] in_win,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_kp,
  output logic               out_bright,
  output logic [PIX_W+2:0]   out_score,
  output logic [CNT_W-1:0]   kp_count
);

  localparam int SW = PIX_W + 3;
  localparam logic [15:0] MASK = 16'((1 << ARC_LEN) - 1);

  logic                 advance;
  logic [PIX_W-1:0]     ctr;
  logic [PIX_W:0]       c_hi;
  logic [7:0]           bright;
  logic [7:0]           dark;
  logic [8*PIX_W-1:0]   diff;

  logic                 s1_valid;
  logic [7:0]           s1_bright;
  logic [7:0]           s1_dark;
  logic [8*PIX_W-1:0]   s1_diff;
  logic [SW-1:0]        sum;
  logic                 arc_b;
  logic                 arc_d;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;
  assign ctr      = in_win[4*PIX_W +: PIX_W];
  assign c_hi     = {1'b0, ctr} + {1'b0, thresh};

  // Ring walks clockwise from the top-left corner.
  localparam int RING [8] = '{0, 1, 2, 5, 8, 7, 6, 3};

  for (genvar i = 0; i < 8; i++) begin : g_ring
    logic [PIX_W-1:0] p;
    logic [PIX_W:0]   p_lo;
    assign p         = in_win[RING[i]*PIX_W +: PIX_W];
    assign p_lo      = {1'b0, p} + {1'b0, thresh};
    assign bright[i] = {1'b0, p} > c_hi;
    assign dark[i]   = p_lo < {1'b0, ctr};
    assign diff[i*PIX_W +: PIX_W] = (p >= ctr) ? p - ctr : ctr - p;
  end

  function automatic logic has_arc(input logic [7:0] f);
    logic [15:0] dbl;
    logic        hit;
    dbl = {f, f};
    hit = 1'b0;
    for (int s = 0; s < 8; s++)
      hit = hit | (((dbl >> s) & MASK) == MASK);
    return hit;
  endfunction

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++)
      sum = sum + SW'(s1_diff[i*PIX_W +: PIX_W]);
  end

  assign arc_b = has_arc(s1_bright);
  assign arc_d = has_arc(s1_dark);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_bright <= bright;
      s1_dark   <= dark;
      s1_diff   <= diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_kp     <= 1'b0;
      out_bright <= 1'b0;
      out_score  <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_kp     <= arc_b | arc_d;
        out_bright <= arc_b;
        out_score  <= sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_count <= '0;
    end else if (frame_start) begin
      kp_count <= '0;
    end else if (out_valid && out_ready && out_kp && kp_count != '1) begin
      kp_count <= kp_count + CNT_W'(1);
    end
  end

endmodule
